// File: rtl/bfloat16_subtractor.sv
// Multi-cycle bfloat16 subtractor: diff = a - b, truncating, denormals flushed to zero.
// Walks unpack -> align -> operate -> normalize, shifting one bit per cycle.
module bfloat16_subtractor (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        start,
    output logic        ready,
    output logic        valid,
    output logic [15:0] diff
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        OP,
        NORM,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        big_sign;
    logic [7:0]  big_exp;
    logic [8:0]  big_sig;
    logic [7:0]  small_sig;
    logic [3:0]  align_cnt;
    logic        eff_sub;

    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic        b_sign_eff;
    logic        a_is_big;
    logic        u_big_sign;
    logic [7:0]  u_big_exp;
    logic [7:0]  u_small_exp;
    logic [6:0]  u_big_mant;
    logic [6:0]  u_small_mant;
    logic [7:0]  exp_delta;
    logic [8:0]  op_sum;
    logic [7:0]  norm_sig;
    logic [7:0]  norm_exp;

    assign a_exp      = op_a[14:7];
    assign b_exp      = op_b[14:7];
    assign b_sign_eff = ~op_b[15];
    assign a_is_big   = (op_a[14:0] >= op_b[14:0]);

    // Order the operands by magnitude; b already carries its flipped sign.
    always_comb begin
        u_big_sign   = op_a[15];
        u_big_exp    = a_exp;
        u_big_mant   = op_a[6:0];
        u_small_exp  = b_exp;
        u_small_mant = op_b[6:0];
        if (!a_is_big) begin
            u_big_sign   = b_sign_eff;
            u_big_exp    = b_exp;
            u_big_mant   = op_b[6:0];
            u_small_exp  = a_exp;
            u_small_mant = op_a[6:0];
        end
    end

    assign exp_delta = u_big_exp - u_small_exp;
    assign op_sum    = eff_sub ? (big_sig - {1'b0, small_sig}) : (big_sig + {1'b0, small_sig});
    assign norm_sig  = {big_sig[6:0], 1'b0};
    assign norm_exp  = big_exp - 8'd1;

    // Sequencer: every path into DONE loads diff and raises valid for the DONE cycle.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            valid     <= 1'b0;
            diff      <= 16'h0000;
            op_a      <= 16'h0000;
            op_b      <= 16'h0000;
            big_sign  <= 1'b0;
            big_exp   <= 8'h00;
            big_sig   <= 9'h000;
            small_sig <= 8'h00;
            align_cnt <= 4'h0;
            eff_sub   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        ready <= 1'b0;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (a_exp == 8'hFF || b_exp == 8'hFF) begin
                        diff  <= 16'h7FC0;
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (a_exp == 8'h00 && b_exp == 8'h00) begin
                        diff  <= 16'h0000;
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (a_exp == 8'h00) begin
                        diff  <= {b_sign_eff, op_b[14:0]};
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (b_exp == 8'h00) begin
                        diff  <= op_a;
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        big_sign  <= u_big_sign;
                        big_exp   <= u_big_exp;
                        big_sig   <= {2'b01, u_big_mant};
                        small_sig <= {1'b1, u_small_mant};
                        eff_sub   <= (op_a[15] != b_sign_eff);
                        align_cnt <= (exp_delta >= 8'd8) ? 4'd8 : exp_delta[3:0];
                        state     <= (exp_delta == 8'd0) ? OP : ALIGN;
                    end
                end
                ALIGN: begin
                    small_sig <= small_sig >> 1;
                    align_cnt <= align_cnt - 4'd1;
                    if (align_cnt == 4'd1) begin
                        state <= OP;
                    end
                end
                OP: begin
                    if (op_sum == 9'd0) begin
                        diff  <= 16'h0000;
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (!op_sum[8] && op_sum[7]) begin
                        diff  <= {big_sign, big_exp, op_sum[6:0]};
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        big_sig <= op_sum;
                        state   <= NORM;
                    end
                end
                NORM: begin
                    // A carry needs exactly one right shift; otherwise walk left until bit 7 is set.
                    if (big_sig[8]) begin
                        if (big_exp == 8'hFE) begin
                            diff <= {big_sign, 8'hFF, 7'h00};
                        end else begin
                            diff <= {big_sign, big_exp + 8'd1, big_sig[7:1]};
                        end
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (norm_exp == 8'd0) begin
                        diff  <= 16'h0000;
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (norm_sig[7]) begin
                        diff  <= {big_sign, norm_exp, norm_sig[6:0]};
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        big_sig <= {1'b0, norm_sig};
                        big_exp <= norm_exp;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
